// File: rtl/traffic_monitor.sv
// Receive-side checker for the one-hot intersection lights bus.
// Tracks the six-phase sequence, measures per-phase dwell and latches the first fault.
module traffic_monitor #(
    parameter int CW        = 5,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 16,
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 6,
    parameter int RED_MIN   = 2,
    parameter int RED_MAX   = 6
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic [5:0]    i_lights,
    output logic [2:0]    o_phase,
    output logic          o_locked,
    output logic [CW-1:0] o_dwell,
    output logic          o_fault,
    output logic [2:0]    o_fault_code,
    output logic [7:0]    o_cycle_count
);

    // state    | meaning
    // ST_SYNC  | waiting for the first legal NS green, no checking
    // ST_TRACK | following the phase sequence, checking order and dwell
    // ST_FAULT | fault latched, outputs frozen until clr
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_ENC   = 3'd1;
    localparam logic [2:0] FC_SEQ   = 3'd2;
    localparam logic [2:0] FC_SHORT = 3'd3;
    localparam logic [2:0] FC_LONG  = 3'd4;

    localparam logic [CW-1:0] L_GREEN_MIN = CW'(GREEN_MIN);
    localparam logic [CW-1:0] L_GREEN_MAX = CW'(GREEN_MAX);
    localparam logic [CW-1:0] L_YEL_MIN   = CW'(YEL_MIN);
    localparam logic [CW-1:0] L_YEL_MAX   = CW'(YEL_MAX);
    localparam logic [CW-1:0] L_RED_MIN   = CW'(RED_MIN);
    localparam logic [CW-1:0] L_RED_MAX   = CW'(RED_MAX);
    localparam logic [CW-1:0] L_DWELL_ONE = CW'(1);
    localparam logic [CW-1:0] L_DWELL_SAT = {CW{1'b1}};

    logic [5:0]    r_lights_q;
    state_t        r_state;
    logic [2:0]    r_phase;
    logic [CW-1:0] r_dwell;
    logic [2:0]    r_code;
    logic [7:0]    r_cycle_cnt;

    state_t        w_state_nx;
    logic [2:0]    w_phase_nx;
    logic [CW-1:0] w_dwell_nx;
    logic [2:0]    w_code_nx;
    logic [7:0]    w_cycle_cnt_nx;

    logic          w_legal;
    logic [2:0]    w_idx;
    logic [2:0]    w_expect;
    logic [CW-1:0] w_dwell_inc;
    logic [CW-1:0] w_min;
    logic [CW-1:0] w_max;

    always_comb begin
        w_legal = $onehot(r_lights_q);
        w_idx   = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (r_lights_q[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // Dwell window of the phase currently held: green, yellow or all-red class.
    always_comb begin
        w_min = L_RED_MIN;
        w_max = L_RED_MAX;
        case (r_phase)
            3'd0, 3'd3: begin
                w_min = L_GREEN_MIN;
                w_max = L_GREEN_MAX;
            end
            3'd1, 3'd4: begin
                w_min = L_YEL_MIN;
                w_max = L_YEL_MAX;
            end
            default: begin
                w_min = L_RED_MIN;
                w_max = L_RED_MAX;
            end
        endcase
    end

    assign w_expect    = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
    assign w_dwell_inc = (r_dwell == L_DWELL_SAT) ? r_dwell : r_dwell + L_DWELL_ONE;

    // Fault branches leave phase and dwell untouched so they freeze at the last good values.
    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_dwell_nx     = r_dwell;
        w_code_nx      = r_code;
        w_cycle_cnt_nx = r_cycle_cnt;
        case (r_state)
            ST_SYNC: begin
                if (w_legal && (w_idx == 3'd0)) begin
                    w_state_nx = ST_TRACK;
                    w_phase_nx = 3'd0;
                    w_dwell_nx = L_DWELL_ONE;
                end
            end
            ST_TRACK: begin
                if (!w_legal) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = FC_ENC;
                end else if (w_idx == r_phase) begin
                    if (w_dwell_inc > w_max) begin
                        w_state_nx = ST_FAULT;
                        w_code_nx  = FC_LONG;
                    end else begin
                        w_dwell_nx = w_dwell_inc;
                    end
                end else if (w_idx != w_expect) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = FC_SEQ;
                end else if (r_dwell < w_min) begin
                    w_state_nx = ST_FAULT;
                    w_code_nx  = FC_SHORT;
                end else begin
                    w_phase_nx = w_idx;
                    w_dwell_nx = L_DWELL_ONE;
                    if (r_phase == 3'd5) begin
                        w_cycle_cnt_nx = r_cycle_cnt + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                w_state_nx = ST_FAULT;
            end
            default: begin
                w_state_nx = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_lights_q  <= 6'd0;
            r_state     <= ST_SYNC;
            r_phase     <= 3'd0;
            r_dwell     <= '0;
            r_code      <= FC_NONE;
            r_cycle_cnt <= 8'd0;
        end else begin
            r_lights_q  <= i_lights;
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_dwell     <= w_dwell_nx;
            r_code      <= w_code_nx;
            r_cycle_cnt <= w_cycle_cnt_nx;
        end
    end

    assign o_phase       = r_phase;
    assign o_locked      = (r_state == ST_TRACK);
    assign o_dwell       = r_dwell;
    assign o_fault       = (r_state == ST_FAULT);
    assign o_fault_code  = r_code;
    assign o_cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor: directed scenarios plus randomized phase runs,
// every cycle compared against a run-length model of the lights stream.
module tb_traffic_monitor;

    localparam int CW    = 5;
    localparam int G_MIN = 8;
    localparam int G_MAX = 16;
    localparam int Y_MIN = 2;
    localparam int Y_MAX = 6;
    localparam int R_MIN = 2;
    localparam int R_MAX = 6;

    logic          i_clk = 1'b0;
    logic          i_clr = 1'b1;
    logic [5:0]    i_lights = 6'd0;
    logic [2:0]    o_phase;
    logic          o_locked;
    logic [CW-1:0] o_dwell;
    logic          o_fault;
    logic [2:0]    o_fault_code;
    logic [7:0]    o_cycle_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: the bus value as seen one cycle late, and the
    // bookkeeping of the current run of identical phases.
    logic [5:0] m_seen;
    bit         m_tracking;
    bit         m_fault;
    int         m_phase;
    int         m_run;
    int         m_code;
    int         m_sequences;

    traffic_monitor #(
        .CW(CW), .GREEN_MIN(G_MIN), .GREEN_MAX(G_MAX),
        .YEL_MIN(Y_MIN), .YEL_MAX(Y_MAX), .RED_MIN(R_MIN), .RED_MAX(R_MAX)
    ) dut (
        .i_clk(i_clk),
        .i_clr(i_clr),
        .i_lights(i_lights),
        .o_phase(o_phase),
        .o_locked(o_locked),
        .o_dwell(o_dwell),
        .o_fault(o_fault),
        .o_fault_code(o_fault_code),
        .o_cycle_count(o_cycle_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] oh(input int p);
        logic [5:0] v;
        v = 6'd1;
        return v << p;
    endfunction

    function automatic int phase_of(input logic [5:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int win_min(input int p);
        if (p % 3 == 0) return G_MIN;
        if (p % 3 == 1) return Y_MIN;
        return R_MIN;
    endfunction

    function automatic int win_max(input int p);
        if (p % 3 == 0) return G_MAX;
        if (p % 3 == 1) return Y_MAX;
        return R_MAX;
    endfunction

    task automatic model_reset();
        m_seen      = 6'd0;
        m_tracking  = 0;
        m_fault     = 0;
        m_phase     = 0;
        m_run       = 0;
        m_code      = 0;
        m_sequences = 0;
    endtask

    task automatic raise(input int code);
        m_fault    = 1;
        m_tracking = 0;
        m_code     = code;
    endtask

    // One clock edge: judge the previously seen bus value, then capture the new one.
    task automatic model_edge(input logic [5:0] v, input bit clr);
        int p;
        if (clr) begin
            model_reset();
            return;
        end
        p = phase_of(m_seen);
        if (m_fault) begin
        end else if (!m_tracking) begin
            if (p == 0) begin
                m_tracking = 1;
                m_phase    = 0;
                m_run      = 1;
            end
        end else if (p < 0) begin
            raise(1);
        end else if (p == m_phase) begin
            if (m_run + 1 > win_max(m_phase)) raise(4);
            else m_run = (m_run + 1 > 31) ? 31 : m_run + 1;
        end else if (p != (m_phase + 1) % 6) begin
            raise(2);
        end else if (m_run < win_min(m_phase)) begin
            raise(3);
        end else begin
            if (m_phase == 5) m_sequences = (m_sequences + 1) % 256;
            m_phase = p;
            m_run   = 1;
        end
        m_seen = v;
    endtask

    task automatic step(input logic [5:0] v, input bit clr = 1'b0);
        i_lights = v;
        i_clr    = clr;
        @(posedge i_clk);
        model_edge(v, clr);
        #1;
        chk("phase", 32'(o_phase), m_phase);
        chk("locked", 32'(o_locked), 32'(m_tracking));
        chk("dwell", 32'(o_dwell), m_run);
        chk("fault", 32'(o_fault), 32'(m_fault));
        chk("fault_code", 32'(o_fault_code), m_code);
        chk("cycle_count", 32'(o_cycle_count), m_sequences);
    endtask

    task automatic do_clr(input int n);
        repeat (n) step(6'd0, 1'b1);
    endtask

    task automatic hold(input int p, input int n);
        repeat (n) step(oh(p));
    endtask

    task automatic sequence6(input int g, input int y, input int r);
        hold(0, g); hold(1, y); hold(2, r);
        hold(3, g); hold(4, y); hold(5, r);
    endtask

    initial begin
        model_reset();

        // Nominal run
        do_clr(2);
        chk("rst_phase", 32'(o_phase), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_dwell", 32'(o_dwell), 0);
        chk("rst_fault", 32'(o_fault), 0);
        chk("rst_code", 32'(o_fault_code), 0);
        chk("rst_cc", 32'(o_cycle_count), 0);
        repeat (3) sequence6(12, 4, 4);
        hold(0, 2);
        chk("nom_cc", 32'(o_cycle_count), 3);
        chk("nom_fault", 32'(o_fault), 0);
        chk("nom_locked", 32'(o_locked), 1);

        // Skipped phase: flag appears exactly two edges after the bad value
        do_clr(1);
        hold(0, 10);
        step(6'b000100);
        chk("seq_lat1", 32'(o_fault), 0);
        step(6'b000100);
        chk("seq_fault", 32'(o_fault), 1);
        chk("seq_code", 32'(o_fault_code), 2);
        chk("seq_phase", 32'(o_phase), 0);

        // Illegal encoding while tracking
        do_clr(1);
        hold(0, 5);
        step(6'b000011);
        step(oh(0));
        chk("enc_code", 32'(o_fault_code), 1);

        // All-dark bus while syncing is ignored
        do_clr(1);
        repeat (5) step(6'd0);
        chk("sync_zero_locked", 32'(o_locked), 0);
        chk("sync_zero_fault", 32'(o_fault), 0);

        // Short yellow
        do_clr(1);
        hold(0, 10); hold(1, 1); hold(2, 3);
        chk("short_code", 32'(o_fault_code), 3);

        // Long EW green
        do_clr(1);
        hold(0, 10); hold(1, 3); hold(2, 3); hold(3, 17);
        chk("long_pre", 32'(o_fault), 0);
        step(oh(3));
        chk("long_code", 32'(o_fault_code), 4);

        // Startup mid-sequence, then LONG, then clr recovery
        do_clr(1);
        hold(3, 5);
        chk("start_locked", 32'(o_locked), 0);
        chk("start_fault", 32'(o_fault), 0);
        hold(0, 2);
        chk("start_lock", 32'(o_locked), 1);
        hold(0, 20);
        chk("start_long", 32'(o_fault_code), 4);
        step(6'd0, 1'b1);
        chk("clr_fault", 32'(o_fault), 0);
        chk("clr_code", 32'(o_fault_code), 0);
        chk("clr_dwell", 32'(o_dwell), 0);
        chk("clr_locked", 32'(o_locked), 0);
        sequence6(8, 2, 2);
        hold(0, 2);
        chk("relock_cc", 32'(o_cycle_count), 1);
        chk("relock_fault", 32'(o_fault), 0);

        // Counter wrap, then ENC beating a simultaneous over-long green
        do_clr(1);
        repeat (256) sequence6(8, 2, 2);
        hold(0, 2);
        chk("wrap_cc", 32'(o_cycle_count), 0);
        chk("wrap_locked", 32'(o_locked), 1);
        hold(0, 14);
        step(6'b001001);
        step(oh(0));
        chk("prio_code", 32'(o_fault_code), 1);

        // Randomized runs with occasional out-of-window dwells and garbage
        for (int k = 0; k < 60; k++) begin
            do_clr($urandom_range(1, 2));
            repeat ($urandom_range(0, 4)) step(6'($urandom));
            repeat ($urandom_range(1, 3)) begin
                for (int p = 0; p < 6; p++) begin
                    int n;
                    n = $urandom_range(win_min(p), win_max(p));
                    if ($urandom_range(0, 15) == 0)
                        n = ($urandom_range(0, 1) == 0) ? win_min(p) - 1 : win_max(p) + 1;
                    hold(p, n);
                    if ($urandom_range(0, 30) == 0) step(6'($urandom));
                end
            end
            hold(0, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
